dual_regfile: RTL and testbench

DUAL_REGFILE -- requirements
Module: dual_regfile

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/dual_regfile.sv | 104 ++++++++++
 tb/tb_dual_regfile.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, types and helpers for the dual-issue regfile.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            en;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_port_t;

  // One-hot register mask; x0 never appears so it can never be marked busy.
  function automatic logic [NREG-1:0] reg_mask(input logic en, input reg_addr_t addr);
    logic [NREG-1:0] m;
    m = '0;
    if (en && (addr != '0)) begin
      m[addr] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register outstanding-write tracking for two issue lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wb0_en,
  input  regfile_pkg::reg_addr_t i_wb0_rd,
  input  logic                  i_wb1_en,
  input  regfile_pkg::reg_addr_t i_wb1_rd,
  input  logic [1:0]            i_iss_en,
  input  regfile_pkg::reg_addr_t i_iss_rd [0:1],
  output logic [NREG-1:0]       o_busy,
  output logic [NREG-1:0]       o_busy_post_wb
);

  import regfile_pkg::*;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_post_wb;
  logic [NREG-1:0] w_busy_nxt;

  // Clears apply first, then sets, so a same-cycle re-issue keeps the bit.
  always_comb begin
    w_clr      = reg_mask(i_wb0_en, i_wb0_rd) | reg_mask(i_wb1_en, i_wb1_rd);
    w_set      = reg_mask(i_iss_en[0], i_iss_rd[0]) | reg_mask(i_iss_en[1], i_iss_rd[1]);
    w_post_wb  = r_busy & ~w_clr;
    w_busy_nxt = w_post_wb | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy         = r_busy;
  assign o_busy_post_wb = w_post_wb;

endmodule
`default_nettype wire

// File: rtl/dual_regfile.sv
`default_nettype none
// ============================================================================
// Module      : dual_regfile
// Description : 4-read / 2-write register file with write bypass and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_regfile #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb0_en,
  input  regfile_pkg::reg_addr_t wb0_rd,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic                   wb1_en,
  input  regfile_pkg::reg_addr_t wb1_rd,
  input  logic [XLEN-1:0]        wb1_data,
  input  regfile_pkg::reg_addr_t ra_addr [0:3],
  output logic [XLEN-1:0]        rd_data [0:3],
  output logic                   hazard  [0:3],
  input  logic [1:0]             iss_en,
  input  regfile_pkg::reg_addr_t iss_rd  [0:1],
  output logic [NREG-1:0]        busy
);

  import regfile_pkg::*;

  localparam int c_NRD = 4;
  localparam int c_NWB = 2;

  wb_port_t        w_wb      [0:c_NWB-1];
  logic [XLEN-1:0] r_regs    [0:NREG-1];
  logic [XLEN-1:0] w_rd_nxt  [0:c_NRD-1];
  logic            w_hz_nxt  [0:c_NRD-1];
  logic [XLEN-1:0] r_rd_data [0:c_NRD-1];
  logic            r_hazard  [0:c_NRD-1];
  logic [NREG-1:0] w_busy_post_wb;

  assign w_wb[0] = '{en: wb0_en, rd: wb0_rd, data: wb0_data};
  assign w_wb[1] = '{en: wb1_en, rd: wb1_rd, data: wb1_data};

  // Lane 1 is iterated last, so its non-blocking write wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) begin
        r_regs[n] <= '0;
      end
    end else begin
      for (int l = 0; l < c_NWB; l++) begin
        if (w_wb[l].en && (w_wb[l].rd != '0)) begin
          r_regs[w_wb[l].rd] <= w_wb[l].data;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < c_NRD; i++) begin
      w_rd_nxt[i] = r_regs[ra_addr[i]];
      for (int l = 0; l < c_NWB; l++) begin
        if (w_wb[l].en && (w_wb[l].rd == ra_addr[i])) begin
          w_rd_nxt[i] = w_wb[l].data;
        end
      end
      w_hz_nxt[i] = w_busy_post_wb[ra_addr[i]];
      if (ra_addr[i] == '0) begin
        w_rd_nxt[i] = '0;
        w_hz_nxt[i] = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < c_NRD; i++) begin : g_rd_port
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data[i] <= '0;
        r_hazard[i]  <= 1'b0;
      end else begin
        r_rd_data[i] <= w_rd_nxt[i];
        r_hazard[i]  <= w_hz_nxt[i];
      end
    end
    assign rd_data[i] = r_rd_data[i];
    assign hazard[i]  = r_hazard[i];
  end

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .i_wb0_en       (wb0_en),
    .i_wb0_rd       (wb0_rd),
    .i_wb1_en       (wb1_en),
    .i_wb1_rd       (wb1_rd),
    .i_iss_en       (iss_en),
    .i_iss_rd       (iss_rd),
    .o_busy         (busy),
    .o_busy_post_wb (w_busy_post_wb)
  );

endmodule
`default_nettype wire

// File: tb/tb_dual_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_regfile
// Description : Directed scoreboard bench for dual_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_regfile;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic        hz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb0_en, wb1_en;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic [4:0]  ra_addr [0:3];
  logic [31:0] rd_data [0:3];
  logic        hazard  [0:3];
  logic [1:0]  iss_en;
  logic [4:0]  iss_rd  [0:1];
  logic [31:0] busy;

  exp_t        q[$];
  exp_t        e_cur;
  logic [4:0]  chk;
  logic [4:0]  chk_d = '0;
  logic        snap = 1'b0;
  logic        done = 1'b0;
  int          total = 0;
  int          bad = 0;

  dual_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .wb0_en   (wb0_en),
    .wb0_rd   (wb0_rd),
    .wb0_data (wb0_data),
    .wb1_en   (wb1_en),
    .wb1_rd   (wb1_rd),
    .wb1_data (wb1_data),
    .ra_addr  (ra_addr),
    .rd_data  (rd_data),
    .hazard   (hazard),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) chk_d <= chk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: snapshot checks on snap, queued checks on every falling edge.
  always @(negedge clk or posedge snap) begin
    if (snap) begin
      cmp("rst_busy", busy, 32'h0);
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("rst_rd_data[%0d]", i), rd_data[i], 32'h0);
        cmp($sformatf("rst_hazard[%0d]", i), {31'h0, hazard[i]}, 32'h0);
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (chk_d[i]) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow: port %0d has no expected entry", i);
          end else begin
            e_cur = q.pop_front();
            if (e_cur.kind != i) begin
              total++;
              bad++;
              $display("FAIL order: got kind %0d want %0d", i, e_cur.kind);
            end else if (i == 4) begin
              cmp("busy", busy, e_cur.val);
            end else begin
              cmp($sformatf("rd_data[%0d]", i), rd_data[i], e_cur.val);
              cmp($sformatf("hazard[%0d]", i), {31'h0, hazard[i]}, {31'h0, e_cur.hz});
            end
          end
        end
      end
      if (done) begin
        cmp("queue_left", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic idle();
    wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0;
    for (int i = 0; i < 4; i++) ra_addr[i] = '0;
    iss_en = '0; iss_rd[0] = '0; iss_rd[1] = '0;
    chk = '0;
  endtask

  task automatic wb(input int l, input logic [4:0] r, input logic [31:0] d);
    if (l == 0) begin wb0_en = 1'b1; wb0_rd = r; wb0_data = d; end
    else        begin wb1_en = 1'b1; wb1_rd = r; wb1_data = d; end
  endtask

  task automatic iss(input int k, input logic [4:0] r);
    iss_en[k] = 1'b1;
    iss_rd[k] = r;
  endtask

  task automatic rd(input int i, input logic [4:0] a, input logic [31:0] d, input logic h);
    ra_addr[i] = a;
    q.push_back('{i, d, h});
    chk[i] = 1'b1;
  endtask

  task automatic exp_busy(input logic [31:0] b);
    q.push_back('{4, b, 1'b0});
    chk[4] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    @(negedge clk);
    @(posedge clk);
    #2 snap = 1'b1;
    #1 snap = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    wb(0, 5'd5, 32'hDEADBEEF); exp_busy(32'h0); tick();
    rd(0, 5'd5, 32'hDEADBEEF, 1'b0); tick();
    wb(0, 5'd7, 32'h11); wb(1, 5'd7, 32'h22);
    rd(2, 5'd7, 32'h22, 1'b0); rd(3, 5'd5, 32'hDEADBEEF, 1'b0); tick();
    rd(0, 5'd6, 32'h0, 1'b0); rd(3, 5'd7, 32'h22, 1'b0); tick();
    wb(1, 5'd0, 32'hFFFFFFFF); rd(1, 5'd0, 32'h0, 1'b0); tick();
    wb(0, 5'd10, 32'hA5A5A5A5);
    rd(0, 5'd10, 32'hA5A5A5A5, 1'b0); rd(1, 5'd0, 32'h0, 1'b0); tick();

    iss(0, 5'd9); rd(0, 5'd9, 32'h0, 1'b0); exp_busy(32'h0000_0200); tick();
    iss(0, 5'd11); iss(1, 5'd11);
    rd(0, 5'd9, 32'h0, 1'b1); exp_busy(32'h0000_0A00); tick();
    wb(0, 5'd9, 32'h99); iss(1, 5'd9);
    rd(2, 5'd9, 32'h99, 1'b0); exp_busy(32'h0000_0A00); tick();
    wb(0, 5'd9, 32'h9A);
    rd(1, 5'd9, 32'h9A, 1'b0); rd(3, 5'd11, 32'h0, 1'b1); exp_busy(32'h0000_0800); tick();
    wb(1, 5'd11, 32'h1111);
    rd(0, 5'd9, 32'h9A, 1'b0); rd(1, 5'd11, 32'h1111, 1'b0); exp_busy(32'h0); tick();

    iss(0, 5'd3); iss(1, 5'd4); exp_busy(32'h0000_0018); tick();
    wb(0, 5'd3, 32'h55);
    rd(0, 5'd3, 32'h55, 1'b0); rd(1, 5'd4, 32'h0, 1'b1); exp_busy(32'h0000_0010); tick();

    // Reset asserted between edges while state is live; inputs meanwhile are junk.
    #2;
    idle();
    rst = 1'b1;
    wb(0, 5'd8, 32'h88); iss(0, 5'd8); ra_addr[0] = 5'd8;
    #1 snap = 1'b1;
    #1 snap = 1'b0;
    @(negedge clk);
    idle();
    rst = 1'b0;

    wb(1, 5'd4, 32'h44);
    rd(0, 5'd3, 32'h0, 1'b0); rd(1, 5'd8, 32'h0, 1'b0); rd(2, 5'd4, 32'h44, 1'b0);
    exp_busy(32'h0); tick();
    rd(0, 5'd8, 32'h0, 1'b0); rd(3, 5'd4, 32'h44, 1'b0); exp_busy(32'h0); tick();
    tick();
    done = 1'b1;
  end

endmodule
`default_nettype wire
